mux21_rr_arbiter: RTL and testbench

Sequential front-end stage that sits directly upstream of the 2:1 mux datapath and generates its select. It accepts two valid/ready input streams (a, b) and arbitrates between them round-robin with a bounded burst length. It forwards the winning word through a one-entry output register, together with the registered select `s` identifying the source. The downstream consumer sees a single valid/ready stream.

---
 rtl/mux21_rr_arbiter.sv | 146 ++++++++++++++
 tb/tb_mux21_rr_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux21_rr_arbiter.sv
// mux21_rr_arbiter
//   Front-end stage for the 2:1 mux datapath. Two valid/ready sources (a, b)
//   are arbitrated round-robin with a bounded burst length, and the winning
//   word is forwarded through a one-entry output register. The registered
//   select s tells the downstream mux which source the held word came from.
//
// Parameters
//   WIDTH      data width of a_data, b_data, y_data
//   MAX_BURST  consecutive grants to one source while the other is
//              requesting (1..15)
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   a_valid/a_data      source A stream in, a_ready accept strobe out
//   b_valid/b_data      source B stream in, b_ready accept strobe out
//   y_valid/y_data      output register contents
//   y_ready             downstream accepts y_data
//   s                   source of y_data: 0 = a, 1 = b
module mux21_rr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             y_valid,
    output logic [WIDTH-1:0] y_data,
    input  logic             y_ready,
    output logic             s
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    localparam logic [3:0] CNT_MAX = 4'(MAX_BURST);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       last, last_nxt;     // 0 = A won last, 1 = B won last

    logic load_en;
    logic pick_a;
    logic pick_b;
    logic xfer;

    // The output register can take a new word when it is empty or being drained.
    assign load_en = !y_valid || y_ready;

    // Combinational pick. At most one of pick_a/pick_b is ever set, and a pick
    // implies the picked side is valid.
    always_comb begin
        pick_a = 1'b0;
        pick_b = 1'b0;
        case (state)
            IDLE: begin
                if (a_valid && b_valid) begin
                    // Tie from idle goes to the side that did not win last.
                    pick_a = last;
                    pick_b = !last;
                end else begin
                    pick_a = a_valid;
                    pick_b = b_valid;
                end
            end
            GRANT_A: begin
                if (a_valid && (!b_valid || cnt < CNT_MAX)) begin
                    pick_a = 1'b1;
                end else begin
                    pick_b = b_valid;
                end
            end
            GRANT_B: begin
                if (b_valid && (!a_valid || cnt < CNT_MAX)) begin
                    pick_b = 1'b1;
                end else begin
                    pick_a = a_valid;
                end
            end
            default: begin
                pick_a = 1'b0;
                pick_b = 1'b0;
            end
        endcase
    end

    assign xfer    = load_en && (pick_a || pick_b);
    assign a_ready = load_en && pick_a;
    assign b_ready = load_en && pick_b;

    // Next-state: burst counting on transfer, drop to IDLE on an empty slot,
    // and hold everything while the output is stalled.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        last_nxt  = last;
        if (xfer) begin
            last_nxt  = pick_b;
            state_nxt = pick_b ? GRANT_B : GRANT_A;
            if ((state == GRANT_A && pick_a) || (state == GRANT_B && pick_b)) begin
                // Saturate so a lone requester keeps its grant indefinitely.
                cnt_nxt = (cnt < CNT_MAX) ? cnt + 4'd1 : CNT_MAX;
            end else begin
                cnt_nxt = 4'd1;
            end
        end else if (load_en) begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            last  <= last_nxt;
        end
    end

    // Output register: word and select are captured together on transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_valid <= 1'b0;
            y_data  <= '0;
            s       <= 1'b0;
        end else if (xfer) begin
            y_valid <= 1'b1;
            y_data  <= pick_b ? b_data : a_data;
            s       <= pick_b;
        end else if (y_ready) begin
            y_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux21_rr_arbiter.sv
module tb_mux21_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic       a_valid;
    logic [7:0] a_data;
    logic       b_valid;
    logic [7:0] b_data;
    logic       y_ready;

    // Instance 0: MAX_BURST=4, instance 1: MAX_BURST=1; both share stimulus.
    logic       a_ready0, b_ready0, y_valid0, s0;
    logic [7:0] y_data0;
    logic       a_ready1, b_ready1, y_valid1, s1;
    logic [7:0] y_data1;

    int n_checks = 0;
    int n_err    = 0;

    mux21_rr_arbiter #(.WIDTH(8), .MAX_BURST(4)) u0 (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready0),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready0),
        .y_valid(y_valid0), .y_data(y_data0), .y_ready(y_ready), .s(s0)
    );

    mux21_rr_arbiter #(.WIDTH(8), .MAX_BURST(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready1),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready1),
        .y_valid(y_valid1), .y_data(y_data1), .y_ready(y_ready), .s(s1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // owner: -1 none, 0 A, 1 B.  last: 0 A, 1 B.
    int         m_owner [2];
    int         m_cnt   [2];
    int         m_last  [2];
    logic       m_yv    [2];
    logic [7:0] m_yd    [2];
    logic       m_s     [2];

    function automatic int maxb(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    // Who gets served from the rules: a lone requester always wins; under
    // contention the current owner keeps it until its burst quota is used,
    // and from idle the side that did not win last goes first.
    function automatic int pick_of(input int k);
        if (a_valid && b_valid) begin
            if (m_owner[k] < 0) return 1 - m_last[k];
            if (m_cnt[k] < maxb(k)) return m_owner[k];
            return 1 - m_owner[k];
        end
        if (a_valid) return 0;
        if (b_valid) return 1;
        return -1;
    endfunction

    function automatic logic room_of(input int k);
        return !m_yv[k] || y_ready;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_owner[k] <= -1;
                m_cnt[k]   <= 0;
                m_last[k]  <= 1;
                m_yv[k]    <= 1'b0;
                m_yd[k]    <= 8'h00;
                m_s[k]     <= 1'b0;
            end else if (room_of(k) && pick_of(k) >= 0) begin
                m_yv[k]    <= 1'b1;
                m_yd[k]    <= (pick_of(k) == 1) ? b_data : a_data;
                m_s[k]     <= (pick_of(k) == 1);
                m_cnt[k]   <= (pick_of(k) == m_owner[k])
                              ? ((m_cnt[k] + 1 > maxb(k)) ? maxb(k) : m_cnt[k] + 1)
                              : 1;
                m_owner[k] <= pick_of(k);
                m_last[k]  <= pick_of(k);
            end else if (room_of(k)) begin
                m_yv[k]    <= 1'b0;
                m_owner[k] <= -1;
                m_cnt[k]   <= 0;
            end
        end
    end

    logic       d_ar [2];
    logic       d_br [2];
    logic       d_yv [2];
    logic [7:0] d_yd [2];
    logic       d_s  [2];
    assign d_ar[0] = a_ready0; assign d_ar[1] = a_ready1;
    assign d_br[0] = b_ready0; assign d_br[1] = b_ready1;
    assign d_yv[0] = y_valid0; assign d_yv[1] = y_valid1;
    assign d_yd[0] = y_data0;  assign d_yd[1] = y_data1;
    assign d_s[0]  = s0;       assign d_s[1]  = s1;

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            check($sformatf("u%0d a_ready", k), 32'(d_ar[k]),
                  32'(room_of(k) && pick_of(k) == 0));
            check($sformatf("u%0d b_ready", k), 32'(d_br[k]),
                  32'(room_of(k) && pick_of(k) == 1));
            check($sformatf("u%0d y_valid", k), 32'(d_yv[k]), 32'(m_yv[k]));
            if (m_yv[k]) begin
                check($sformatf("u%0d y_data", k), 32'(d_yd[k]), 32'(m_yd[k]));
                check($sformatf("u%0d s", k), 32'(d_s[k]), 32'(m_s[k]));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [11:0] seq0;
        seq0 = 12'h0F0;   // bit n = expected s of transfer n for MAX_BURST=4

        rst_n   = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_data  = 8'h00;
        b_data  = 8'h00;
        y_ready = 1'b1;
        step();
        check("reset y_valid", 32'(y_valid0), 32'd0);
        check("reset y_data", 32'(y_data0), 32'd0);
        check("reset s", 32'(s0), 32'd0);
        step();

        // Contention from reset: first tie to A, bursts of 4 / strict alternation.
        rst_n   = 1'b1;
        a_valid = 1'b1;
        b_valid = 1'b1;
        for (int n = 0; n < 12; n++) begin
            a_data = 8'hA0 + 8'(n);
            b_data = 8'hB0 + 8'(n);
            step();
            check($sformatf("burst4 s[%0d]", n), 32'(s0), 32'(seq0[n]));
            check($sformatf("burst4 data[%0d]", n), 32'(y_data0),
                  32'(seq0[n] ? 8'hB0 + 8'(n) : 8'hA0 + 8'(n)));
            check($sformatf("burst1 s[%0d]", n), 32'(s1), 32'(n % 2));
            check($sformatf("burst1 valid[%0d]", n), 32'(y_valid1), 32'd1);
        end

        // Backpressure with a held 0x55.
        a_data = 8'h55;
        b_data = 8'h55;
        step();
        check("bp load data", 32'(y_data0), 32'h55);
        check("bp load s", 32'(s0), 32'd1);
        y_ready = 1'b0;
        a_data  = 8'h77;
        b_data  = 8'h77;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("bp a_ready", 32'(a_ready0), 32'd0);
            check("bp b_ready", 32'(b_ready0), 32'd0);
            step();
            check("bp hold data", 32'(y_data0), 32'h55);
            check("bp hold s", 32'(s0), 32'd1);
        end
        y_ready = 1'b1;
        @(negedge clk);
        check("bp resume b_ready", 32'(b_ready0), 32'd1);
        step();
        check("bp resume data", 32'(y_data0), 32'h77);

        // Idle tie-break after a B grant.
        a_valid = 1'b0;
        b_valid = 1'b0;
        step();
        check("idle y_valid fall", 32'(y_valid0), 32'd0);
        step();
        a_valid = 1'b1;
        b_valid = 1'b1;
        a_data  = 8'h21;
        b_data  = 8'h31;
        @(negedge clk);
        check("idle tie a_ready", 32'(a_ready0), 32'd1);
        step();
        check("idle tie s", 32'(s0), 32'd0);
        check("idle tie data", 32'(y_data0), 32'h21);

        // A only, no gaps in either build.
        b_valid = 1'b0;
        for (int n = 0; n < 4; n++) begin
            a_data = 8'h11 + 8'(n);
            @(negedge clk);
            check("aonly a_ready", 32'(a_ready0), 32'd1);
            check("aonly b_ready", 32'(b_ready0), 32'd0);
            check("aonly u1 a_ready", 32'(a_ready1), 32'd1);
            step();
            check("aonly data", 32'(y_data0), 32'(8'h11 + 8'(n)));
            check("aonly s", 32'(s0), 32'd0);
            check("aonly u1 data", 32'(y_data1), 32'(8'h11 + 8'(n)));
        end

        // Mixed valids and ready; checked by the model only.
        for (int i = 0; i < 30; i++) begin
            a_valid = (i % 4) != 3;
            b_valid = (i % 3) != 0;
            y_ready = (i % 5) != 2;
            a_data  = 8'h40 + 8'(i);
            b_data  = 8'h80 + 8'(i);
            step();
        end

        // Reset in the middle of a held B word.
        a_valid = 1'b0;
        b_valid = 1'b1;
        y_ready = 1'b1;
        b_data  = 8'h66;
        step();
        check("midrst pre valid", 32'(y_valid0), 32'd1);
        check("midrst pre s", 32'(s0), 32'd1);
        a_valid = 1'b1;
        a_data  = 8'h99;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst y_valid", 32'(y_valid0), 32'd0);
        check("midrst y_data", 32'(y_data0), 32'd0);
        check("midrst s", 32'(s0), 32'd0);
        check("midrst u1 y_valid", 32'(y_valid1), 32'd0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("post rst a_ready", 32'(a_ready0), 32'd1);
        check("post rst b_ready", 32'(b_ready0), 32'd0);
        step();
        check("post rst s", 32'(s0), 32'd0);
        check("post rst data", 32'(y_data0), 32'h99);
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
